// File: rtl/shift_rot_pkg.sv
// Shared operation encoding and helpers for the pipelined shifter/rotator.
package shift_rot_pkg;

   typedef enum logic [2:0] {
      OP_SLL = 3'b000,
      OP_SRL = 3'b001,
      OP_SRA = 3'b010,
      OP_ROL = 3'b011,
      OP_ROR = 3'b100
   } shift_op_t;

   function automatic logic is_right(input logic [2:0] op);
      return (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
   endfunction

endpackage

// File: rtl/shift_rot_stage.sv
// One shift/rotate step by SHAMT (a power of two) followed by a valid/ready register.
// Carry tracking is present only when SHIFT_ROT_PIPE_CARRY_EN is defined.
module shift_rot_stage
   import shift_rot_pkg::*;
#(
   parameter int N     = 16,
   parameter int SHAMT = 1,
   parameter int C     = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ld,
   input  logic         in_valid,
   input  logic [N-1:0] in_data,
   input  logic [C-1:0] in_cnt,
   input  logic [2:0]   in_op,
`ifdef SHIFT_ROT_PIPE_CARRY_EN
   input  logic         in_carry,
   output logic         carry_q,
`endif
   output logic         v_q,
   output logic [N-1:0] data_q,
   output logic [C-1:0] cnt_q,
   output logic [2:0]   op_q
);

   localparam int K = $clog2(SHAMT);

   logic                shift_en;
   logic signed [N-1:0] sx;
   logic [N-1:0]        data_d;

   // Reserved ops fall through the default arm, behaving like cnt = 0.
   always_comb begin
      sx       = in_data;
      data_d   = in_data;
      shift_en = 1'b0;
      if (in_cnt[K]) begin
         shift_en = 1'b1;
         case (in_op)
            OP_SLL:  data_d = in_data << SHAMT;
            OP_SRL:  data_d = in_data >> SHAMT;
            OP_SRA:  data_d = sx >>> SHAMT;
            OP_ROL:  data_d = (in_data << SHAMT) | (in_data >> (N - SHAMT));
            OP_ROR:  data_d = (in_data >> SHAMT) | (in_data << (N - SHAMT));
            default: shift_en = 1'b0;
         endcase
      end
   end

`ifdef SHIFT_ROT_PIPE_CARRY_EN
   logic carry_d;

   always_comb begin
      carry_d = in_carry;
      if (shift_en) carry_d = is_right(in_op) ? in_data[SHAMT-1] : in_data[N-SHAMT];
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q     <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
         op_q    <= '0;
`ifdef SHIFT_ROT_PIPE_CARRY_EN
         carry_q <= 1'b0;
`endif
      end else if (ld) begin
         v_q     <= in_valid;
         data_q  <= data_d;
         cnt_q   <= in_cnt;
         op_q    <= in_op;
`ifdef SHIFT_ROT_PIPE_CARRY_EN
         carry_q <= carry_d;
`endif
      end
   end

endmodule

// File: rtl/shift_rot_pipe.sv
// Pipelined N-bit shifter/rotator: log2(N) registered stages with valid/ready flow control.
// Define SHIFT_ROT_PIPE_CARRY_EN to track the last bit shifted out on out_carry.
module shift_rot_pipe
   import shift_rot_pkg::*;
#(
   parameter int N = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_data,
   input  logic [$clog2(N)-1:0] in_cnt,
   input  logic [2:0]           in_op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         out_data,
   output logic                 out_carry
);

   localparam int C = $clog2(N);

   // Index 0 is the input port; index k+1 is the register of stage k.
   logic [C:0]   v;
   logic [N-1:0] d   [C+1];
   logic [C-1:0] cnt [C+1];
   logic [2:0]   op  [C+1];
   logic [C-1:0] rdy;

   assign v[0]   = in_valid;
   assign d[0]   = in_data;
   assign cnt[0] = in_cnt;
   assign op[0]  = in_op;

`ifdef SHIFT_ROT_PIPE_CARRY_EN
   logic [C:0] cy;
   assign cy[0]     = 1'b0;
   assign out_carry = cy[C];
`else
   assign out_carry = 1'b0;
`endif

   genvar k;
   generate
      for (k = 0; k < C; k++) begin : g_stage
         // Closed form of the ready chain: a stage may load unless it and everything after it is full and stalled.
         assign rdy[k] = out_ready | ~(&v[C:k+1]);

         shift_rot_stage #(
            .N     (N),
            .SHAMT (1 << k),
            .C     (C)
         ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .ld       (rdy[k]),
            .in_valid (v[k]),
            .in_data  (d[k]),
            .in_cnt   (cnt[k]),
            .in_op    (op[k]),
`ifdef SHIFT_ROT_PIPE_CARRY_EN
            .in_carry (cy[k]),
            .carry_q  (cy[k+1]),
`endif
            .v_q      (v[k+1]),
            .data_q   (d[k+1]),
            .cnt_q    (cnt[k+1]),
            .op_q     (op[k+1])
         );
      end
   endgenerate

   assign in_ready  = rdy[0];
   assign out_valid = v[C];
   assign out_data  = d[C];

   logic unused_tail;
   assign unused_tail = ^{cnt[C], op[C]};

endmodule

// File: doc/shift_rot_pipe.md
# shift_rot_pipe

Parametrised, pipelined shifter/rotator for the execute stage: successor to the 16-bit combinational logical-left shifter, generalised to power-of-two width N and five shift/rotate modes. Each log2(N) shift stage is followed by a register, so the block sustains one operation per cycle with a fixed latency. Valid/ready handshakes on both sides let the ALU stall it without losing operations.

## Interface
- N, 16, data width; power of two, ≥ 2
- C, $clog2(N), count width and stage count (derived localparam, not overridable)
- clk  input  1  clock, all state rising-edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation offered
- in_ready  output  1  block can accept this cycle
- in_data  input  N  operand
- in_cnt  input  C  shift amount 0..N-1
- in_op  input  3  mode: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others reserved
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts
- out_data  output  N  result
- out_carry  output  1  last bit shifted out (only with SHIFT_ROT_PIPE_CARRY_EN)

## Operation
- C stages. Stage k (k = 0..C-1) shifts by 2^k when cnt[k] = 1, else passes its input.
- Each stage register holds valid, data, remaining cnt, op, and carry.
- SLL: zero fill at the LSB end. SRL: zero fill at the MSB end. SRA: fill with the MSB of the operand as it entered the block.
- ROL/ROR: bits leaving one end re-enter at the other.
- Reserved op: treated as cnt = 0, so data passes through unchanged and carry = 0.
- Carry update in a stage with cnt[k] = 1, where x is that stage's input:
  - SLL/ROL: carry = x[N-2^k]
  - SRL/SRA/ROR: carry = x[2^k-1]
- Stages with cnt[k] = 0 keep the incoming carry. Carry enters stage 0 as 0.
- Handshake:
  - rdy[C] = out_ready
  - rdy[k] = !v[k] || rdy[k+1]
  - in_ready = rdy[0]
- Stage k loads when rdy[k] is high: from stage k-1 (or the input port) together with its valid bit.
- A transfer occurs on valid && ready. in_ready is combinationally dependent on out_ready through the chain; this is intended.
- Bubbles collapse: an empty stage loads even while downstream is stalled.

## Timing
- Reset (async assert, sync release): all stage valids 0, data/carry registers 0. out_valid = 0, out_data = 0, out_carry = 0, in_ready = 1.
- Latency: an op accepted at edge t appears with out_valid = 1 after edge t+C-1, i.e. C register stages. N=16 gives 4 cycles.
- Throughput: 1 op/cycle with out_ready held high.
- out_ready low with the last stage valid: out_data/out_carry/out_valid held stable until accepted. Upstream stages fill remaining bubbles, then in_ready drops.
- Full pipe with out_ready going high: accept and emit in the same cycle, no bubble.
- Reset mid-operation: all in-flight ops discarded, no output produced.
- cnt = 0: data passes unchanged, carry = 0, same latency.

## Configuration
- SHIFT_ROT_PIPE_CARRY_EN defined: carry tracked per stage and driven on out_carry.
- Not defined: out_carry tied to 0 and the carry registers omitted. Data behaviour is identical.

## Structure
- Package shift_rot_pkg: typedef enum logic [2:0] shift_op_t (OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR) and function is_right(op).
- Sub-module shift_rot_stage, parameters N and SHAMT = 2^k:
  - one combinational shift/rotate step
  - carry select
  - valid/ready register
- Top instantiates C stages in a generate loop.

## Test plan
- Reset, then SLL N=16 0x00F1 cnt=4 -> out_data 0x0F10, carry 0, out_valid exactly 4 cycles after accept.
- SRA 0x8001 cnt=1 -> 0xC000, carry 1. SRL 0x8001 cnt=15 -> 0x0001, carry 0.
- ROL 0x8001 cnt=1 -> 0x0003, carry 1. ROR 0x0003 cnt=1 -> 0x8001, carry 1. Reserved op 111 on 0x1234 cnt=5 -> 0x1234, carry 0.
- Back-to-back stream of 20 random ops with out_ready=1 -> in_ready never drops, results in order matching the reference model.
- Hold out_ready=0 for 8 cycles while offering ops -> exactly C ops accepted, in_ready low, out_data stable. Release -> all drain in order with no loss or duplication.
- Assert rst_n low with pipe full -> out_valid 0 immediately (asynchronous), no stale results after release.
